// File: rtl/clock_seq_pkg.sv
// Shared types and constants for the clock-group reset sequencer.
package clock_seq_pkg;

    localparam int unsigned NUM_GROUPS_DEF = 6;

    localparam int unsigned GRP_IMPLICIT = 0;
    localparam int unsigned GRP_SBUS     = 1;
    localparam int unsigned GRP_PBUS     = 2;
    localparam int unsigned GRP_FBUS     = 3;
    localparam int unsigned GRP_MBUS     = 4;
    localparam int unsigned GRP_CBUS     = 5;

    typedef enum logic [1:0] {
        StIdle,
        StSeq,
        StDone,
        StPulse
    } seq_state_e;

endpackage

// File: rtl/clock_seq_hold_counter.sv
// Hold-interval counter: latches max(hold_cycles,1) on load and strobes expire
// on the last cycle of each interval while run is high.
module clock_seq_hold_counter #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              run,
    output logic              expire
);

    logic [HOLD_W-1:0] hq_d, hq_q;
    logic [HOLD_W-1:0] cnt_d, cnt_q;

    assign expire = run && (cnt_q == hq_q - HOLD_W'(1));

    always_comb begin
        hq_d  = hq_q;
        cnt_d = cnt_q;
        if (load) begin
            hq_d  = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            cnt_d = '0;
        end else if (run) begin
            // Restart at zero so back-to-back intervals stay exactly Hq long.
            cnt_d = expire ? '0 : cnt_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hq_q  <= HOLD_W'(1);
            cnt_q <= '0;
        end else begin
            hq_q  <= hq_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Power-up reset-release sequencer and per-group reset pulser for the clock groups.
// Optional pulse counter output enabled by defining CLK_SEQ_PULSE_COUNT_EN.
module clock_group_reset_sequencer
    import clock_seq_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int unsigned HOLD_W     = 8,
    parameter int unsigned GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [HOLD_W-1:0]     hold_cycles,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [GRP_W-1:0]      req_group,
    output logic [NUM_GROUPS-1:0] group_rst_out,
    output logic                  seq_done,
    output logic                  busy,
    output logic                  req_err
`ifdef CLK_SEQ_PULSE_COUNT_EN
    ,
    output logic [15:0]           pulse_count
`endif
);

    seq_state_e            state_d, state_q;
    logic [GRP_W-1:0]      idx_d, idx_q;
    logic [NUM_GROUPS-1:0] grp_d, grp_q;
    logic                  seq_done_d, seq_done_q;
    logic                  busy_d, busy_q;
    logic                  req_err_d, req_err_q;
    logic                  hc_load, hc_run, hc_expire;
    logic                  pulse_fin;

    clock_seq_hold_counter #(
        .HOLD_W(HOLD_W)
    ) u_hold_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (hc_load),
        .hold_cycles(hold_cycles),
        .run        (hc_run),
        .expire     (hc_expire)
    );

    assign req_ready = (state_q == StDone) && !start;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        grp_d      = grp_q;
        seq_done_d = seq_done_q;
        req_err_d  = 1'b0;
        hc_load    = 1'b0;
        hc_run     = 1'b0;
        pulse_fin  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hc_load = 1'b1;
                    idx_d   = '0;
                    grp_d   = '1;
                    state_d = StSeq;
                end
            end
            StSeq: begin
                hc_run = 1'b1;
                if (hc_expire) begin
                    grp_d[idx_q] = 1'b0;
                    if (idx_q == GRP_W'(NUM_GROUPS - 1)) begin
                        idx_d      = '0;
                        seq_done_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        idx_d = idx_q + GRP_W'(1);
                    end
                end
            end
            StDone: begin
                if (start) begin
                    hc_load    = 1'b1;
                    idx_d      = '0;
                    grp_d      = '1;
                    seq_done_d = 1'b0;
                    state_d    = StSeq;
                end else if (req_valid) begin
                    if (32'(req_group) < NUM_GROUPS) begin
                        hc_load          = 1'b1;
                        idx_d            = req_group;
                        grp_d[req_group] = 1'b1;
                        state_d          = StPulse;
                    end else begin
                        req_err_d = 1'b1;
                    end
                end
            end
            StPulse: begin
                hc_run = 1'b1;
                if (hc_expire) begin
                    grp_d[idx_q] = 1'b0;
                    pulse_fin    = 1'b1;
                    state_d      = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StSeq) || (state_d == StPulse);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            grp_q      <= '1;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            grp_q      <= grp_d;
            seq_done_q <= seq_done_d;
            busy_q     <= busy_d;
            req_err_q  <= req_err_d;
        end
    end

    assign group_rst_out = grp_q;
    assign seq_done      = seq_done_q;
    assign busy          = busy_q;
    assign req_err       = req_err_q;

`ifdef CLK_SEQ_PULSE_COUNT_EN
    logic [15:0] pulse_count_d, pulse_count_q;

    always_comb begin
        pulse_count_d = pulse_count_q;
        if (pulse_fin && (pulse_count_q != 16'hFFFF)) begin
            pulse_count_d = pulse_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pulse_count_q <= '0;
        end else begin
            pulse_count_q <= pulse_count_d;
        end
    end

    assign pulse_count = pulse_count_q;
`else
    logic unused_pulse_fin;
    assign unused_pulse_fin = pulse_fin;
`endif

endmodule
